// File: rtl/hdc_pkg.sv
// Shared sizing constants and FSM encoding for the HDC associative-memory classifier.
package hdc_pkg;

    localparam int DIMENSIONS  = 10000;
    localparam int NUM_CLASSES = 2;
    localparam int CHUNK_WIDTH = 512;

    localparam int NUM_CHUNKS = (DIMENSIONS + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int DIST_W     = $clog2(DIMENSIONS + 1);
    localparam int POP_W      = $clog2(CHUNK_WIDTH + 1);
    localparam int CLASS_W    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int ADDR_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int LAST_BITS  = DIMENSIONS - (NUM_CHUNKS - 1) * CHUNK_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_COMPARE,
        ST_DONE
    } cls_state_e;

    // Keeps only the real hypervector bits of the final chunk.
    function automatic logic [CHUNK_WIDTH-1:0] last_chunk_mask();
        logic [CHUNK_WIDTH-1:0] m;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            m[i] = (i < LAST_BITS);
        end
        return m;
    endfunction

endpackage

// File: rtl/hdc_popcount.sv
// Combinational population count of a W-bit vector.
module hdc_popcount #(
    parameter int W = 512
) (
    input  logic [W-1:0]             bits_i,
    output logic [$clog2(W+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(W + 1);

    // NOTE: always_comb uses blocking assignments and assigns a default first, so no latch is inferred.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + CNT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/hdc_assoc_classifier.sv
// Chunk-serial Hamming-distance associative memory: scores a query hypervector against
// every stored class prototype in parallel and reports the nearest class.
module hdc_assoc_classifier
    import hdc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hv_valid,
    output logic                    hv_ready,
    input  logic [DIMENSIONS-1:0]   window_hv,
    input  logic                    proto_we,
    input  logic [CLASS_W-1:0]      proto_class,
    input  logic [ADDR_W-1:0]       proto_addr,
    input  logic [CHUNK_WIDTH-1:0]  proto_wdata,
    output logic                    pred_valid,
    input  logic                    pred_ready,
    output logic [CLASS_W-1:0]      pred_class,
    output logic [DIST_W-1:0]       pred_dist
);

    localparam int                      PAD_W      = NUM_CHUNKS * CHUNK_WIDTH;
    localparam logic [CHUNK_WIDTH-1:0]  LAST_MASK  = last_chunk_mask();
    localparam logic [ADDR_W-1:0]       LAST_CHUNK = ADDR_W'(NUM_CHUNKS - 1);

    cls_state_e             state_q;
    logic [ADDR_W-1:0]      chunk_q;
    logic [PAD_W-1:0]       hv_q;
    logic [DIST_W-1:0]      acc_q [NUM_CLASSES];
    logic [DIST_W-1:0]      acc_d [NUM_CLASSES];
    logic                   hv_ready_q;
    logic                   pred_valid_q;
    logic [CLASS_W-1:0]     pred_class_q;
    logic [DIST_W-1:0]      pred_dist_q;
    logic [CHUNK_WIDTH-1:0] proto_q [NUM_CLASSES][NUM_CHUNKS];

    logic [CHUNK_WIDTH-1:0] chunk_mask;
    logic [CHUNK_WIDTH-1:0] diff [NUM_CLASSES];
    logic [POP_W-1:0]       pop  [NUM_CLASSES];
    logic [CLASS_W-1:0]     best_class;
    logic [DIST_W-1:0]      best_dist;
    logic                   accept;

    assign accept     = (state_q == ST_IDLE) && hv_valid && hv_ready_q;
    assign chunk_mask = (chunk_q == LAST_CHUNK) ? LAST_MASK : '1;

    // The query is shifted down one chunk per ACCUM cycle, so the current chunk is always the low slice.
    generate
        for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
            assign diff[c] = (hv_q[CHUNK_WIDTH-1:0] ^ proto_q[c][chunk_q]) & chunk_mask;

            hdc_popcount #(.W(CHUNK_WIDTH)) u_popcount (
                .bits_i  (diff[c]),
                .count_o (pop[c])
            );
        end
    endgenerate

    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            acc_d[c] = acc_q[c] + DIST_W'(pop[c]);
        end
    end

    // Strict less-than keeps the lowest class index on a tie.
    always_comb begin
        best_class = '0;
        best_dist  = acc_q[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (acc_q[c] < best_dist) begin
                best_class = CLASS_W'(c);
                best_dist  = acc_q[c];
            end
        end
    end

    // NOTE: prototype storage and the query register carry no reset; they are pure data, fully written before use.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && proto_we && int'(proto_addr) < NUM_CHUNKS) begin
            proto_q[proto_class][proto_addr] <= proto_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hv_q <= PAD_W'(window_hv);
        end else if (state_q == ST_ACCUM) begin
            hv_q <= hv_q >> CHUNK_WIDTH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            chunk_q      <= '0;
            hv_ready_q   <= 1'b1;
            pred_valid_q <= 1'b0;
            pred_class_q <= '0;
            pred_dist_q  <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        chunk_q    <= '0;
                        hv_ready_q <= 1'b0;
                        state_q    <= ST_ACCUM;
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            acc_q[c] <= '0;
                        end
                    end
                end
                ST_ACCUM: begin
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        acc_q[c] <= acc_d[c];
                    end
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_q <= '0;
                        state_q <= ST_COMPARE;
                    end else begin
                        chunk_q <= chunk_q + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    pred_class_q <= best_class;
                    pred_dist_q  <= best_dist;
                    pred_valid_q <= 1'b1;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    if (pred_ready) begin
                        pred_valid_q <= 1'b0;
                        hv_ready_q   <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign hv_ready   = hv_ready_q;
    assign pred_valid = pred_valid_q;
    assign pred_class = pred_class_q;
    assign pred_dist  = pred_dist_q;

endmodule

// File: tb/tb_hdc_assoc_classifier.sv
// Directed self-checking bench for hdc_assoc_classifier; expected results are hand-computed Hamming distances.
module tb_hdc_assoc_classifier;
    import hdc_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   hv_valid;
    logic                   hv_ready;
    logic [DIMENSIONS-1:0]  window_hv;
    logic                   proto_we;
    logic [CLASS_W-1:0]     proto_class;
    logic [ADDR_W-1:0]      proto_addr;
    logic [CHUNK_WIDTH-1:0] proto_wdata;
    logic                   pred_valid;
    logic                   pred_ready;
    logic [CLASS_W-1:0]     pred_class;
    logic [DIST_W-1:0]      pred_dist;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hdc_assoc_classifier dut (
        .clk         (clk),
        .rst         (rst),
        .hv_valid    (hv_valid),
        .hv_ready    (hv_ready),
        .window_hv   (window_hv),
        .proto_we    (proto_we),
        .proto_class (proto_class),
        .proto_addr  (proto_addr),
        .proto_wdata (proto_wdata),
        .pred_valid  (pred_valid),
        .pred_ready  (pred_ready),
        .pred_class  (pred_class),
        .pred_dist   (pred_dist)
    );

    function automatic logic [DIMENSIONS-1:0] ones_low(input int n);
        logic [DIMENSIONS-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_chunk(input int cls, input int addr, input logic [CHUNK_WIDTH-1:0] data);
        proto_we    = 1'b1;
        proto_class = CLASS_W'(cls);
        proto_addr  = ADDR_W'(addr);
        proto_wdata = data;
        tick();
        proto_we    = 1'b0;
    endtask

    task automatic load_proto(input int cls, input logic [CHUNK_WIDTH-1:0] data);
        for (int k = 0; k < NUM_CHUNKS; k++) write_chunk(cls, k, data);
    endtask

    task automatic send_hv(input string name, input logic [DIMENSIONS-1:0] hv);
        int waited;
        waited = 0;
        while (hv_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (hv_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s hv_ready: got %b expected 1", name, hv_ready);
        end
        hv_valid  = 1'b1;
        window_hv = hv;
        tick();
        hv_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (pred_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string name, input int exp_class, input int exp_dist);
        checks++;
        if (pred_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s pred_valid: got %b expected 1", name, pred_valid);
        end
        checks++;
        if (pred_class !== CLASS_W'(exp_class)) begin
            errors++;
            $display("FAIL %s pred_class: got %0d expected %0d", name, pred_class, exp_class);
        end
        checks++;
        if (pred_dist !== DIST_W'(exp_dist)) begin
            errors++;
            $display("FAIL %s pred_dist: got %0d expected %0d", name, pred_dist, exp_dist);
        end
    endtask

    task automatic ack();
        pred_ready = 1'b1;
        tick();
        pred_ready = 1'b0;
    endtask

    task automatic classify(input string name, input logic [DIMENSIONS-1:0] hv,
                            input int exp_class, input int exp_dist);
        int lat;
        send_hv(name, hv);
        wait_valid(lat);
        checks++;
        if (lat !== NUM_CHUNKS + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, NUM_CHUNKS + 1);
        end
        check_result(name, exp_class, exp_dist);
        ack();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (hv_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset hv_ready: got %b expected 1", hv_ready);
        end
        checks++;
        if (pred_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset pred_valid: got %b expected 0", pred_valid);
        end
        checks++;
        if (pred_class !== '0) begin
            errors++;
            $display("FAIL reset pred_class: got %0d expected 0", pred_class);
        end
        checks++;
        if (pred_dist !== '0) begin
            errors++;
            $display("FAIL reset pred_dist: got %0d expected 0", pred_dist);
        end
    endtask

    task automatic test_basic();
        load_proto(0, '0);
        load_proto(1, '1);
        classify("basic_3000", ones_low(3000), 0, 3000);
    endtask

    task automatic test_tie();
        classify("tie_5000", ones_low(5000), 0, 5000);
        classify("near1_7000", ones_low(7000), 1, 3000);
    endtask

    task automatic test_padding();
        logic [CHUNK_WIDTH-1:0] pad;
        pad = '0;
        for (int i = LAST_BITS; i < CHUNK_WIDTH; i++) pad[i] = 1'b1;
        write_chunk(0, NUM_CHUNKS - 1, pad);
        classify("pad_zero_hv", '0, 0, 0);
        classify("pad_ones_hv", ones_low(DIMENSIONS), 1, 0);
    endtask

    task automatic test_backpressure();
        int lat;
        send_hv("bp", ones_low(3000));
        wait_valid(lat);
        check_result("bp_first", 0, 3000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_result("bp_hold", 0, 3000);
            checks++;
            if (hv_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold hv_ready: got %b expected 0 at cycle %0d", hv_ready, i);
            end
        end
        pred_ready = 1'b1;
        tick();
        pred_ready = 1'b0;
        checks++;
        if (pred_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release pred_valid: got %b expected 0", pred_valid);
        end
        tick();
        checks++;
        if (hv_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release hv_ready: got %b expected 1", hv_ready);
        end
    endtask

    task automatic test_write_protect();
        int lat;
        // proto1 zeroing of chunks 0..9 during ACCUM must be ignored
        send_hv("wp_busy", ones_low(7000));
        tick();
        for (int k = 0; k < 10; k++) write_chunk(1, k, '0);
        wait_valid(lat);
        check_result("wp_busy", 1, 3000);
        ack();
        for (int k = 0; k < 10; k++) write_chunk(1, k, '0);
        classify("wp_idle", ones_low(7000), 0, 7000);
        for (int k = 0; k < 9; k++) write_chunk(1, k, '1);
        // Restore chunk 9 in the same cycle the query is accepted.
        proto_we    = 1'b1;
        proto_class = CLASS_W'(1);
        proto_addr  = ADDR_W'(9);
        proto_wdata = '1;
        hv_valid    = 1'b1;
        window_hv   = ones_low(7000);
        tick();
        proto_we    = 1'b0;
        hv_valid    = 1'b0;
        wait_valid(lat);
        checks++;
        if (lat !== NUM_CHUNKS + 1) begin
            errors++;
            $display("FAIL wp_same_cycle latency: got %0d expected %0d", lat, NUM_CHUNKS + 1);
        end
        check_result("wp_same_cycle", 1, 3000);
        ack();
    endtask

    task automatic test_reset_midflight();
        bit seen_valid;
        send_hv("rst_mid", ones_low(3000));
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (hv_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid hv_ready: got %b expected 1", hv_ready);
        end
        checks++;
        if (pred_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid pred_valid: got %b expected 0", pred_valid);
        end
        checks++;
        if (pred_dist !== '0) begin
            errors++;
            $display("FAIL rst_mid pred_dist: got %0d expected 0", pred_dist);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (pred_valid === 1'b1) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid stale_pulse: got pred_valid pulse expected none");
        end
        classify("rst_after", ones_low(7000), 1, 3000);
    endtask

    initial begin
        rst         = 1'b1;
        hv_valid    = 1'b0;
        window_hv   = '0;
        proto_we    = 1'b0;
        proto_class = '0;
        proto_addr  = '0;
        proto_wdata = '0;
        pred_ready  = 1'b0;

        test_reset();
        test_basic();
        test_tie();
        test_padding();
        test_backpressure();
        test_write_protect();
        test_reset_midflight();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
